// File: rtl/five_in_row_checker.sv
// Five-in-a-row checker: walks the board outward from a freshly placed stone in four directions.
// Optional macro FIVE_IN_ROW_EXACT_FIVE_EN: only a run of exactly five wins (overlines lose).

module five_in_row_checker (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] move_xy,
    input  logic [1:0] player,
    output logic [7:0] rd_select,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [3:0] max_run
);

`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
    localparam int unsigned MAXSTEP = 5;
`else
    localparam int unsigned MAXSTEP = 4;
`endif
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_CAP = RUN_W'(MAXSTEP + 1);

    typedef enum logic [1:0] {IDLE, POS, NEG, FIN} state_e;
    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [CNT_W-1:0]   side_cnt_q, side_cnt_d, pos_cnt_q, pos_cnt_d, side_cnt_n;
    logic               oob_q, oob_d, hit;
    logic [7:0]         mv_q, mv_d, rd_select_q, rd_select_d;
    logic [1:0]         pl_q, pl_d;
    logic               busy_q, busy_d, done_q, done_d, win_q, win_d;
    logic [RUN_W-1:0]   max_run_q, max_run_d, run_raw, run_sat;
    logic [8:0]         nxt, first;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
    logic               five_hit_q, five_hit_d;
`endif

    // One step from base along dir (negated on the NEG side); bit 8 flags leaving the board.
    function automatic logic [8:0] step_xy(input logic [7:0] b, input dir_e d, input logic neg);
        logic [4:0] dx, dy, nx, ny;
        dx = (d == DIR_V) ? 5'd0 : 5'd1;
        dy = (d == DIR_H) ? 5'd0 : ((d == DIR_A) ? 5'h1f : 5'd1);
        if (neg) begin
            dx = 5'd0 - dx;
            dy = 5'd0 - dy;
        end
        nx = {1'b0, b[7:4]} + dx;
        ny = {1'b0, b[3:0]} + dy;
        return {nx[4] | ny[4], nx[3:0], ny[3:0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        side_cnt_d  = side_cnt_q;
        pos_cnt_d   = pos_cnt_q;
        oob_d       = oob_q;
        mv_d        = mv_q;
        pl_d        = pl_q;
        rd_select_d = rd_select_q;
        win_d       = win_q;
        max_run_d   = max_run_q;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
        five_hit_d  = five_hit_q;
`endif
        hit         = 1'b0;
        side_cnt_n  = side_cnt_q;
        run_raw     = '0;
        run_sat     = '0;
        first       = '0;
        nxt         = step_xy(rd_select_q, dir_q, state_q == NEG);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    win_d     = 1'b0;
                    max_run_d = '0;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
                    five_hit_d = 1'b0;
`endif
                    if (player == 2'b01 || player == 2'b10) begin
                        mv_d       = move_xy;
                        pl_d       = player;
                        dir_d      = DIR_H;
                        side_cnt_d = '0;
                        pos_cnt_d  = '0;
                        first      = step_xy(move_xy, DIR_H, 1'b0);
                        oob_d      = first[8];
                        if (!first[8]) rd_select_d = first[7:0];
                        state_d    = POS;
                    end else begin
                        state_d    = FIN;
                    end
                end
            end
            POS, NEG: begin
                // A boundary cycle never looks at rd_data.
                hit        = !oob_q && (rd_data == pl_q);
                side_cnt_n = side_cnt_q + CNT_W'(hit);
                if (hit && (side_cnt_n < CNT_W'(MAXSTEP))) begin
                    side_cnt_d = side_cnt_n;
                    oob_d      = nxt[8];
                    if (!nxt[8]) rd_select_d = nxt[7:0];
                end else begin
                    side_cnt_d = '0;
                    if (state_q == POS) begin
                        pos_cnt_d = side_cnt_n;
                        first     = step_xy(mv_q, dir_q, 1'b1);
                        oob_d     = first[8];
                        if (!first[8]) rd_select_d = first[7:0];
                        state_d   = NEG;
                    end else begin
                        run_raw = RUN_W'(1) + RUN_W'(pos_cnt_q) + RUN_W'(side_cnt_n);
                        run_sat = (run_raw > RUN_CAP) ? RUN_CAP : run_raw;
                        if (run_sat > max_run_q) max_run_d = run_sat;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
                        if (run_sat == RUN_W'(5)) five_hit_d = 1'b1;
`endif
                        if (dir_q == DIR_A) begin
                            state_d = FIN;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
                            win_d   = five_hit_d;
`else
                            win_d   = (max_run_d >= RUN_W'(5));
`endif
                        end else begin
                            dir_d   = dir_e'(dir_q + 2'd1);
                            first   = step_xy(mv_q, dir_e'(dir_q + 2'd1), 1'b0);
                            oob_d   = first[8];
                            if (!first[8]) rd_select_d = first[7:0];
                            state_d = POS;
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dir_q       <= DIR_H;
            side_cnt_q  <= '0;
            pos_cnt_q   <= '0;
            oob_q       <= 1'b0;
            mv_q        <= '0;
            pl_q        <= '0;
            rd_select_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_q       <= 1'b0;
            max_run_q   <= '0;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
            five_hit_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            side_cnt_q  <= side_cnt_d;
            pos_cnt_q   <= pos_cnt_d;
            oob_q       <= oob_d;
            mv_q        <= mv_d;
            pl_q        <= pl_d;
            rd_select_q <= rd_select_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_q       <= win_d;
            max_run_q   <= max_run_d;
`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
            five_hit_q  <= five_hit_d;
`endif
        end
    end

    assign rd_select = rd_select_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign win       = win_q;
    assign max_run   = max_run_q;

endmodule

// File: tb/tb_five_in_row_checker.sv
// Bench for five_in_row_checker: board model drives rd_data; a scoreboard predicts probe trace,
// latency, win and max_run for every accepted start.

module tb_five_in_row_checker;

`ifdef FIVE_IN_ROW_EXACT_FIVE_EN
    localparam int MAXSTEP = 5;
    localparam bit EXACT   = 1'b1;
`else
    localparam int MAXSTEP = 4;
    localparam bit EXACT   = 1'b0;
`endif

    logic       clock;
    logic       reset = 1'b1;
    logic       start;
    logic [7:0] move_xy;
    logic [1:0] player;
    logic [7:0] rd_select;
    logic [1:0] rd_data;
    logic       busy, done, win;
    logic [3:0] max_run;

    logic [1:0] board [256];
    assign rd_data = board[rd_select];

    five_in_row_checker dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .move_xy  (move_xy),
        .player   (player),
        .rd_select(rd_select),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .win      (win),
        .max_run  (max_run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         lat;
        bit         win;
        logic [3:0] mr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_tr[$];
    logic [7:0] last_sel;
    int         n_cmp = 0;
    int         n_err = 0;
    int         DX [4] = '{1, 0, 1, 1};
    int         DY [4] = '{0, 1, 1, -1};

    task automatic clear_board();
        for (int i = 0; i < 256; i++) board[i] = 2'b00;
    endtask

    // Reference walk: expected probe addresses, cycle count and result.
    task automatic predict(input logic [7:0] mv, input logic [1:0] pl);
        exp_t e;
        int   n [2];
        int   x, y, sg, run, best;
        bit   five;
        e.lat = 0;
        best  = 0;
        five  = 1'b0;
        if (pl == 2'b01 || pl == 2'b10) begin
            for (int d = 0; d < 4; d++) begin
                for (int s = 0; s < 2; s++) begin
                    sg   = (s == 0) ? 1 : -1;
                    n[s] = 0;
                    x    = int'(mv[7:4]);
                    y    = int'(mv[3:0]);
                    for (int k = 0; k < MAXSTEP; k++) begin
                        x = x + sg * DX[d];
                        y = y + sg * DY[d];
                        e.lat++;
                        if (x < 0 || x > 15 || y < 0 || y > 15) begin
                            exp_tr.push_back(last_sel);
                            break;
                        end
                        last_sel = 8'(x * 16 + y);
                        exp_tr.push_back(last_sel);
                        if (board[x * 16 + y] != pl) break;
                        n[s]++;
                    end
                end
                run = 1 + n[0] + n[1];
                if (run > MAXSTEP + 1) run = MAXSTEP + 1;
                if (run > best) best = run;
                if (run == 5) five = 1'b1;
            end
        end
        e.mr  = 4'(best);
        e.win = EXACT ? five : (best >= 5);
        exp_q.push_back(e);
    endtask

    // Issue one start, follow the scan to done and compare against the scoreboard.
    task automatic run_check(input string name, input logic [7:0] mv, input logic [1:0] pl,
                             input bit hold);
        exp_t       e;
        int         lat;
        bit         busy_ok, tr_ok;
        logic [7:0] obs[$];
        predict(mv, pl);
        move_xy = mv;
        player  = pl;
        start   = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            obs.push_back(rd_select);
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        end
        n_cmp++;
        if (busy !== 1'b1 || !busy_ok) begin
            n_err++;
            $display("FAIL %s busy: at_done=%b during_scan_ok=%0d want 1/1", name, busy, busy_ok);
        end
        n_cmp++;
        if (win !== e.win) begin
            n_err++;
            $display("FAIL %s win: got %b want %b", name, win, e.win);
        end
        n_cmp++;
        if (max_run !== e.mr) begin
            n_err++;
            $display("FAIL %s max_run: got %0d want %0d", name, max_run, e.mr);
        end
        tr_ok = (obs.size() == exp_tr.size());
        for (int i = 0; i < obs.size() && tr_ok; i++)
            if (obs[i] !== exp_tr[i]) tr_ok = 1'b0;
        n_cmp++;
        if (!tr_ok) begin
            n_err++;
            $display("FAIL %s probe_trace: got %0d entries (first %h) want %0d entries (first %h)",
                     name, obs.size(), (obs.size() > 0) ? obs[0] : 8'h00,
                     exp_tr.size(), (exp_tr.size() > 0) ? exp_tr[0] : 8'h00);
        end
        exp_tr.delete();
        n_cmp++;
        if (rd_select !== last_sel) begin
            n_err++;
            $display("FAIL %s rd_select_at_done: got %h want %h", name, rd_select, last_sel);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: done=%b busy=%b want 0/0", name, done, busy);
        end
        n_cmp++;
        if (win !== e.win || max_run !== e.mr) begin
            n_err++;
            $display("FAIL %s held_result: win=%b max_run=%0d want %b/%0d",
                     name, win, max_run, e.win, e.mr);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (rd_select !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
            win !== 1'b0 || max_run !== 4'd0) begin
            n_err++;
            $display("FAIL %s reset_outputs: rd_select=%h busy=%b done=%b win=%b max_run=%0d want all 0",
                     name, rd_select, busy, done, win, max_run);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clock);
        #1 check_zero("reset_held");
        @(negedge clock);
        reset    = 1'b1;
        last_sel = 8'h00;
    endtask

    task automatic test_empty_center();
        clear_board();
        run_check("empty_center", 8'h77, 2'b01, 1'b0);
    endtask

    task automatic test_row_five();
        clear_board();
        for (int x = 3; x <= 7; x++) board[x * 16 + 5] = 2'b01;
        run_check("row_five", 8'h55, 2'b01, 1'b0);
    endtask

    task automatic test_invalid_player();
        run_check("invalid_11", 8'h33, 2'b11, 1'b0);
        test_row_five();
        run_check("invalid_00", 8'h44, 2'b00, 1'b0);
    endtask

    task automatic test_corner();
        clear_board();
        run_check("corner_00", 8'h00, 2'b01, 1'b0);
        run_check("corner_ff", 8'hff, 2'b10, 1'b0);
    endtask

    task automatic test_overline();
        clear_board();
        for (int x = 3; x <= 8; x++) board[x * 16 + 5] = 2'b01;
        run_check("overline_six", 8'h55, 2'b01, 1'b0);
    endtask

    task automatic test_maxstep();
        clear_board();
        for (int x = 1; x <= 9; x++) board[x * 16 + 5] = 2'b10;
        for (int k = 1; k <= 4; k++) board[(5 + k) * 16 + (5 - k)] = 2'b01;
        run_check("maxstep_row9", 8'h55, 2'b10, 1'b0);
        run_check("anti_diag_blocked", 8'h55, 2'b01, 1'b0);
    endtask

    task automatic test_hold_start();
        clear_board();
        for (int k = -2; k <= 2; k++) board[(7 + k) * 16 + (7 + k)] = 2'b10;
        run_check("hold_start_diag", 8'h77, 2'b10, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_check("b2b_first", 8'h77, 2'b10, 1'b0);
        run_check("b2b_second", 8'h66, 2'b01, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] mv;
        logic [1:0] pl;
        int         d, x, y, v;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) begin
                v = $urandom_range(0, 4);
                board[i] = (v == 1) ? 2'b01 : ((v == 2) ? 2'b10 : 2'b00);
            end
            mv = 8'($urandom_range(0, 255));
            pl = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            d  = $urandom_range(0, 3);
            board[mv] = pl;
            for (int t = -4; t <= 4; t++) begin
                x = int'(mv[7:4]) + t * DX[d];
                y = int'(mv[3:0]) + t * DY[d];
                if (x >= 0 && x <= 15 && y >= 0 && y <= 15 && $urandom_range(0, 9) < 8)
                    board[x * 16 + y] = pl;
            end
            run_check($sformatf("random_%0d", r), mv, pl, 1'b0);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_board();
        board[8 * 16 + 7] = 2'b01;
        board[9 * 16 + 7] = 2'b01;
        move_xy = 8'h77;
        player  = 2'b01;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || max_run !== 4'd3) begin
            n_err++;
            $display("FAIL mid_scan_state: busy=%b max_run=%0d want 1/3", busy, max_run);
        end
        #2 reset = 1'b0;
        #1 check_zero("reset_mid_scan");
        @(posedge clock); #1;
        check_zero("reset_mid_scan_held");
        @(negedge clock);
        reset    = 1'b1;
        last_sel = 8'h00;
        run_check("after_mid_reset", 8'h77, 2'b01, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        start    = 1'b0;
        move_xy  = 8'h00;
        player   = 2'b00;
        last_sel = 8'h00;
        clear_board();
        test_reset();
        test_empty_center();
        test_row_five();
        test_invalid_player();
        test_corner();
        test_overline();
        test_maxstep();
        test_hold_start();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/five_in_row_checker.md
FIVE_IN_ROW_CHECKER -- requirements
Module: five_in_row_checker

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-003 SHALL have port: start  input  1  request a check of the move on move_xy/player; sampled only in IDLE.
REQ-004 SHALL have port: move_xy  input  8  coordinate of the stone just placed: [7:4]=x, [3:0]=y.
REQ-005 SHALL have port: player  input  2  colour of the stone just placed: 01 or 10; 00 and 11 invalid.
REQ-006 SHALL have port: rd_select  output  8  board read address to the board read port: [7:4]=x, [3:0]=y.
REQ-007 SHALL have port: rd_data  input  2  cell contents at rd_select, returned combinationally in the same cycle.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; win and max_run valid.
REQ-010 SHALL have port: win  output  1  move completes a winning line; held until next accepted start.
REQ-011 SHALL have port: max_run  output  4  longest same-colour run through the move over all four directions; held like win.

Function
REQ-012 SHALL implement states IDLE, POS, NEG, FIN; FIN lasts one cycle, asserts done, then returns to IDLE.
REQ-013 SHALL latch move_xy and player, clear win/max_run, and enter POS in direction H when start=1 in IDLE with valid player.
REQ-014 SHALL go IDLE->FIN with win=0, max_run=0, and no probes when start=1 with player 00 or 11.
REQ-015 SHALL ignore start outside IDLE.
REQ-016 SHALL scan directions in order H(+1,0), V(0,+1), D(+1,+1), A(+1,-1); POS steps +delta, NEG steps -delta, starting from the move cell at each side.
REQ-017 SHALL treat the move cell as counted (run starts at 1) and never read it.
REQ-018 SHALL consume exactly one cycle per probe: rd_select = next coordinate; rd_data==player -> count+1, advance; else side ends.
REQ-019 SHALL end a side without using rd_data when the next coordinate leaves 0..15 on either axis; that cycle is still consumed with rd_select unchanged.
REQ-020 SHALL end a side after MAXSTEP matches without a further probe; MAXSTEP=4 by default (see REQ-028).
REQ-021 SHALL, at end of NEG, compute run=1+pos+neg, update max_run=max(max_run,run), and enter POS of next direction, or FIN after A.
REQ-022 SHALL always scan all four directions; no early exit on win.
REQ-023 SHALL set win in FIN per the win rule (REQ-028); default: win = (max_run >= 5).
REQ-024 SHALL keep busy=1 in POS/NEG/FIN and 0 in IDLE.

Reset
REQ-025 SHALL, on reset low, return to IDLE regardless of state (including mid-scan) and discard the latched move.
REQ-026 SHALL reset outputs: rd_select=8'h00, busy=0, done=0, win=0, max_run=0.
REQ-027 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL support macro FIVE_IN_ROW_EXACT_FIVE_EN: when defined, MAXSTEP=5 and win=1 only if some direction run equals exactly 5 (overlines of 6+ do not win); when undefined, MAXSTEP=4 and win = (max_run >= 5).

Verification
REQ-029 SHALL pass: empty board, move (7,7) player 01, start at edge k -> 8 probe cycles, done at cycle k+9, win=0, max_run=1.
REQ-030 SHALL pass: player 01 stones at x=3..7, y=5; move (5,5) -> H 3+3 probes, others 2 each, done at k+13, win=1, max_run=5.
REQ-031 SHALL pass: move (0,0) on empty board -> negative sides end on boundary, still 8 probe cycles, rd_select never wraps to 15, win=0.
REQ-032 SHALL pass: stones x=3..8, y=5, move (5,5) -> macro undefined: win=1, max_run=5; macro defined: win=0, max_run=6.
REQ-033 SHALL pass: reset pulsed low during NEG of V -> busy/done/win/max_run/rd_select all 0 immediately; next start gives a fresh, correct result.
REQ-034 SHALL pass: start with player=11 -> done one cycle later, win=0, max_run=0, rd_select unchanged; start held high during a scan is ignored.
